// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: address/frame layouts for the default
// 16-set build and a small address helper used by the cache and its users.
package icache_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    // Memory only ever sees word addresses, so the byte offset is forced to zero.
    function automatic word_t wordAlign(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// The cache uses the slave view; the datapath/memory side uses the master view.
interface icache_if;
    import icache_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block, read-only instruction cache with
// zero-cycle hits, blocking miss fills and saturating hit/miss counters.
module icache
    import icache_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    icache_if.slave          cif,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, FILL} icache_state_t;

    icache_state_t    state;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    word_t            data [SETS];

    logic             iRenQ;
    word_t            iaddrQ;

    logic [TAG_W-1:0] reqTag;
    logic [IDX_W-1:0] reqIdx;
    logic [TAG_W-1:0] missTag;
    logic [IDX_W-1:0] missIdx;
    logic             hit;
    logic             fillDone;

    // iaddrQ doubles as the latched miss address for the whole fill.
    assign reqTag   = cif.imemaddr[31:IDX_W+2];
    assign reqIdx   = cif.imemaddr[IDX_W+1:2];
    assign missTag  = iaddrQ[31:IDX_W+2];
    assign missIdx  = iaddrQ[IDX_W+1:2];

    assign hit      = (state == IDLE) && cif.imemREN && valid[reqIdx] && (tags[reqIdx] == reqTag);
    assign fillDone = (state == FILL) && !cif.iwait;

    assign cif.ihit     = hit;
    assign cif.imemload = hit ? data[reqIdx] : '0;
    assign cif.iREN     = iRenQ;
    assign cif.iaddr    = iaddrQ;

    // A fill cannot be aborted by the fetch side; only reset cancels it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            iRenQ  <= 1'b0;
            iaddrQ <= '0;
            valid  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cif.imemREN && !hit) begin
                        state  <= FILL;
                        iRenQ  <= 1'b1;
                        iaddrQ <= wordAlign(cif.imemaddr);
                    end
                end
                FILL: begin
                    if (!cif.iwait) begin
                        valid[missIdx] <= 1'b1;
                        state          <= IDLE;
                        iRenQ          <= 1'b0;
                        iaddrQ         <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (fillDone) begin
            tags[missIdx] <= missTag;
            data[missIdx] <= cif.iload;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
            if (fillDone && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hit words and fill
// addresses, an independent monitor pops and compares them as the cache responds.
module tb_icache;
    import icache_pkg::*;

    logic        CLK;
    logic        RST;
    logic [31:0] hc;
    logic [31:0] mc;
    logic [3:0]  hc4;
    logic [3:0]  mc4;

    icache_if bus ();
    icache_if sbus ();

    icache #(.SETS(16), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .cif(bus.slave), .hit_cnt(hc), .miss_cnt(mc)
    );

    icache #(.SETS(16), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .cif(sbus.slave), .hit_cnt(hc4), .miss_cnt(mc4)
    );

    int    checks = 0;
    int    errors = 0;
    int    memWait = 3;
    int    expHit = 0;
    int    expMiss = 0;
    word_t hitQ[$];
    word_t fillQ[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic word_t memWord(input word_t a);
        if (a == 32'h0000_0004) return 32'h2001_0001;
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Memory model: holds iwait for memWait cycles of each request, then returns data.
    initial begin
        int waitLeft;
        waitLeft = 3;
        bus.iwait = 1'b1;
        bus.iload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.iREN) begin
                if (waitLeft > 0) begin
                    bus.iwait = 1'b1;
                    waitLeft--;
                end else begin
                    bus.iwait = 1'b0;
                    bus.iload = memWord(bus.iaddr);
                end
            end else begin
                bus.iwait = 1'b1;
                waitLeft  = memWait;
            end
        end
    end

    initial begin
        sbus.iwait    = 1'b0;
        sbus.iload    = 32'h1234_5678;
        sbus.imemREN  = 1'b1;
        sbus.imemaddr = 32'h0000_0010;
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.ihit) begin
                if (hitQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_hit: got ihit=1 imemload=0x%08h required ihit=0", bus.imemload);
                end else begin
                    checkOutput("hit_word", bus.imemload, hitQ.pop_front());
                    checkOutput("hit_iREN", 32'(bus.iREN), 32'd0);
                end
            end
            if (bus.iREN && !bus.iwait) begin
                if (fillQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_fill: got iaddr=0x%08h required no fill", bus.iaddr);
                end else begin
                    checkOutput("fill_addr", bus.iaddr, fillQ.pop_front());
                end
            end
        end
    end

    task automatic waitHits(input int n);
        int got = 0;
        int budget = 0;
        while (got < n && budget < 60) begin
            @(negedge CLK);
            budget++;
            if (bus.ihit) got++;
        end
        checkOutput("hit_timeout", 32'(got), 32'(n));
    endtask

    // Called in the posedge+1 phase; returns in the same phase with imemREN low.
    task automatic applyStimulus(input word_t addr, input word_t word, input bit isMiss, input int nHits);
        if (isMiss) begin
            fillQ.push_back({addr[31:2], 2'b00});
            expMiss++;
        end
        for (int i = 0; i < nHits; i++) hitQ.push_back(word);
        expHit += nHits;
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        waitHits(nHits);
        @(posedge CLK);
        #1;
        bus.imemREN = 1'b0;
    endtask

    initial begin
        RST          = 1'b1;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0004;
        repeat (2) @(negedge CLK);
        checkOutput("rst_ihit", 32'(bus.ihit), 32'd0);
        checkOutput("rst_imemload", bus.imemload, 32'd0);
        checkOutput("rst_iREN", 32'(bus.iREN), 32'd0);
        checkOutput("rst_iaddr", bus.iaddr, 32'd0);
        checkOutput("rst_hit_cnt", hc, 32'd0);
        checkOutput("rst_miss_cnt", mc, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Cold miss on 0x4 with three wait cycles.
        fillQ.push_back(32'h0000_0004);
        hitQ.push_back(32'h2001_0001);
        expMiss = 1;
        expHit  = 1;
        @(negedge CLK);
        checkOutput("t1_first_ihit", 32'(bus.ihit), 32'd0);
        checkOutput("t1_first_iREN", 32'(bus.iREN), 32'd0);
        @(negedge CLK);
        checkOutput("t1_fill_iREN", 32'(bus.iREN), 32'd1);
        checkOutput("t1_fill_iaddr", bus.iaddr, 32'h0000_0004);
        waitHits(1);
        @(posedge CLK);
        #1;
        bus.imemREN = 1'b0;
        @(negedge CLK);
        checkOutput("t1_miss_cnt", mc, 32'd1);
        checkOutput("t1_hit_cnt", hc, 32'd1);

        // Five back-to-back warm hits.
        @(posedge CLK);
        #1;
        applyStimulus(32'h0000_0004, 32'h2001_0001, 1'b0, 5);
        @(negedge CLK);
        checkOutput("t2_hit_cnt", hc, 32'd6);
        checkOutput("t2_miss_cnt", mc, 32'd1);

        // Conflict on index 1 evicts and re-misses.
        @(posedge CLK);
        #1;
        applyStimulus(32'h0000_0044, 32'hC0DE_0044, 1'b1, 1);
        applyStimulus(32'h0000_0007, 32'h2001_0001, 1'b1, 1);
        @(negedge CLK);
        checkOutput("t3_miss_cnt", mc, 32'd3);

        // Redirect and drop of imemREN while 0x8 is filling.
        @(posedge CLK);
        #1;
        fillQ.push_back(32'h0000_0008);
        fillQ.push_back(32'h0000_0100);
        hitQ.push_back(32'hC0DE_0100);
        expMiss += 2;
        expHit  += 1;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0008;
        @(posedge CLK);
        #1;
        bus.imemaddr = 32'h0000_0100;
        bus.imemREN  = 1'b0;
        @(posedge CLK);
        #1;
        bus.imemREN = 1'b1;
        waitHits(1);
        @(posedge CLK);
        #1;
        applyStimulus(32'h0000_0008, 32'hC0DE_0008, 1'b0, 2);
        @(negedge CLK);
        checkOutput("t4_miss_cnt", mc, 32'(expMiss));
        checkOutput("t4_hit_cnt", hc, 32'(expHit));

        // Reset in the middle of a stalled fill.
        @(posedge CLK);
        #1;
        memWait      = 10;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0014;
        repeat (2) @(negedge CLK);
        checkOutput("t5_fill_iREN", 32'(bus.iREN), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("t5_rst_iREN", 32'(bus.iREN), 32'd0);
        checkOutput("t5_rst_iaddr", bus.iaddr, 32'd0);
        checkOutput("t5_rst_miss_cnt", mc, 32'd0);
        bus.imemREN = 1'b0;
        expHit  = 0;
        expMiss = 0;
        @(posedge CLK);
        #1;
        RST     = 1'b0;
        memWait = 3;
        applyStimulus(32'h0000_0008, 32'hC0DE_0008, 1'b1, 1);
        @(negedge CLK);
        checkOutput("t5_miss_cnt", mc, 32'd1);
        checkOutput("t5_hit_cnt", hc, 32'd1);

        // Narrow counters saturate under continuous hits.
        repeat (20) @(negedge CLK);
        checkOutput("t6_hit_sat", 32'(hc4), 32'h0000_000F);
        checkOutput("t6_miss_cnt", 32'(mc4), 32'd1);
        repeat (3) @(negedge CLK);
        checkOutput("t6_hit_hold", 32'(hc4), 32'h0000_000F);

        checkOutput("hitq_empty", 32'(hitQ.size()), 32'd0);
        checkOutput("fillq_empty", 32'(fillQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
